// File: rtl/multicycle_proc_core.sv
// multicycle_proc_core: multi-cycle CPU executing the 4-bit-opcode ISA over one shared
// req/ack memory port. FETCH -> DECODE -> EXEC -> {MEM | WB | FETCH}, HALT on illegal opcode.
// Optional build macro: MULTICYCLE_PERF_CNT_EN adds cycle_cnt/instret_cnt outputs.
module multicycle_proc_core #(
    parameter int               DBITS               = 32,
    parameter int               REG_INDEX_BIT_WIDTH = 4,
    parameter logic [DBITS-1:0] START_PC            = DBITS'(32'h40)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [DBITS-1:0] pc_out,
    output logic             retire,
    output logic             halted
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instret_cnt
`endif
);

    localparam int NREGS = 2 ** REG_INDEX_BIT_WIDTH;

    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_BCOND = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [DBITS-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0]      ir_q, ir_d;
    logic [DBITS-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic [DBITS-1:0] regs_q [NREGS];
    logic [DBITS-1:0] regs_d [NREGS];
    logic             req_s, we_s, retire_s;
    logic [DBITS-1:0] addr_s, wdata_s, pc4_s, op2_s;

    logic [3:0]                     op_s, fn_s;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd_s, rs1_s, rs2_s;
    assign op_s  = ir_q[31:28];
    assign fn_s  = ir_q[27:24];
    assign rd_s  = ir_q[20 +: REG_INDEX_BIT_WIDTH];
    assign rs1_s = ir_q[16 +: REG_INDEX_BIT_WIDTH];
    assign rs2_s = ir_q[8 +: REG_INDEX_BIT_WIDTH];

    function automatic logic [DBITS-1:0] alu_f(input logic [3:0] fn,
                                               input logic [DBITS-1:0] a, input logic [DBITS-1:0] b);
        case (fn)
            4'h0:    alu_f = a + b;
            4'h1:    alu_f = a - b;
            4'h4:    alu_f = a & b;
            4'h5:    alu_f = a | b;
            4'h6:    alu_f = a ^ b;
            4'hC:    alu_f = ~(a & b);
            4'hD:    alu_f = ~(a | b);
            4'hE:    alu_f = ~(a ^ b);
            default: alu_f = {DBITS{1'b0}};
        endcase
    endfunction

    // Signed compare; unassigned condition codes evaluate false.
    function automatic logic cmp_f(input logic [3:0] fn,
                                   input logic [DBITS-1:0] a, input logic [DBITS-1:0] b);
        case (fn)
            4'h0:    cmp_f = 1'b0;
            4'h1:    cmp_f = (a == b);
            4'h2:    cmp_f = ($signed(a) < $signed(b));
            4'h3:    cmp_f = ($signed(a) <= $signed(b));
            4'h8:    cmp_f = 1'b1;
            4'h9:    cmp_f = (a != b);
            4'hA:    cmp_f = ($signed(a) >= $signed(b));
            4'hB:    cmp_f = ($signed(a) > $signed(b));
            default: cmp_f = 1'b0;
        endcase
    endfunction

    // ALU opcodes with an unassigned fn are treated as illegal, like an unknown op1.
    function automatic logic legal_f(input logic [3:0] op, input logic [3:0] fn);
        case (op)
            OP_ALUR, OP_ALUI: legal_f = (fn inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE});
            OP_CMPR, OP_CMPI, OP_BCOND, OP_SW, OP_LW, OP_JAL: legal_f = 1'b1;
            default: legal_f = 1'b0;
        endcase
    endfunction

    assign pc4_s = pc_q + DBITS'(32'd4);
    assign op2_s = ((op_s == OP_ALUI) || (op_s == OP_CMPI)) ? imm_q : b_q;

    // Next-state, datapath updates and memory-port drive for the current state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        npc_d    = npc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        res_d    = res_q;
        regs_d   = regs_q;
        req_s    = 1'b0;
        we_s     = 1'b0;
        addr_s   = {DBITS{1'b0}};
        wdata_s  = {DBITS{1'b0}};
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_s  = 1'b1;
                addr_s = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d   = regs_q[rs1_s];
                b_d   = ((op_s == OP_ALUR) || (op_s == OP_CMPR)) ? regs_q[rs2_s] : regs_q[rd_s];
                imm_d = {{(DBITS-16){ir_q[15]}}, ir_q[15:0]};
                if (legal_f(op_s, fn_s)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                npc_d = pc4_s;
                case (op_s)
                    OP_ALUR, OP_ALUI: begin
                        res_d   = alu_f(fn_s, a_q, op2_s);
                        state_d = S_WB;
                    end
                    OP_CMPR, OP_CMPI: begin
                        res_d   = {{(DBITS-1){1'b0}}, cmp_f(fn_s, a_q, op2_s)};
                        state_d = S_WB;
                    end
                    OP_BCOND: begin
                        // Branch compares reg[rt] (latched in B) against reg[rs1] (latched in A).
                        if (cmp_f(fn_s, b_q, a_q)) begin
                            pc_d = pc4_s + (imm_q << 2);
                        end else begin
                            pc_d = pc4_s;
                        end
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_SW, OP_LW: begin
                        res_d   = a_q + imm_q;
                        state_d = S_MEM;
                    end
                    OP_JAL: begin
                        res_d   = pc4_s;
                        npc_d   = a_q + (imm_q << 2);
                        state_d = S_WB;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                req_s   = 1'b1;
                we_s    = (op_s == OP_SW);
                addr_s  = res_q;
                wdata_s = (op_s == OP_SW) ? b_q : {DBITS{1'b0}};
                if (mem_ack) begin
                    if (op_s == OP_SW) begin
                        pc_d     = npc_q;
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                regs_d[rd_s] = res_q;
                pc_d         = npc_q;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Architectural and micro-architectural state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= START_PC;
            npc_q   <= {DBITS{1'b0}};
            ir_q    <= 32'h0000_0000;
            a_q     <= {DBITS{1'b0}};
            b_q     <= {DBITS{1'b0}};
            imm_q   <= {DBITS{1'b0}};
            res_q   <= {DBITS{1'b0}};
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DBITS{1'b0}};
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Port drive decoded from state; reset masks the request at once so no access survives it.
    assign mem_req   = req_s & ~reset;
    assign mem_we    = we_s & ~reset;
    assign mem_addr  = reset ? {DBITS{1'b0}} : addr_s;
    assign mem_wdata = reset ? {DBITS{1'b0}} : wdata_s;
    assign retire    = retire_s & ~reset;
    assign halted    = (state_q == S_HALT);
    assign pc_out    = pc_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    // Counter next values: cycles run until halt, instructions count on retire.
    always_comb begin
        cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instret_cnt_d = retire_s ? instret_cnt_q + 32'd1 : instret_cnt_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_proc_core.sv
// tb_multicycle_proc_core: directed tests of multicycle_proc_core against a behavioural memory.
module tb_multicycle_proc_core;

    localparam logic [3:0] ALUR = 4'h0, ALUI = 4'h8, CMPR = 4'h2, CMPI = 4'hA;
    localparam logic [3:0] BCOND = 4'h6, SW = 4'h5, LW = 4'h9, JAL = 4'hB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    int          wait_cnt;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    int          n_checks = 0;
    int          n_fail = 0;

    multicycle_proc_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
        .retire(retire), .halted(halted)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = (st_valid && (mem_addr == st_addr)) ? st_data : mem[mem_addr[9:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
            st_valid <= 1'b0;
            st_addr  <= 32'h0;
            st_data  <= 32'h0;
        end else if (mem_req && mem_ack) begin
            wait_cnt <= 0;
            if (mem_we) begin
                st_valid <= 1'b1;
                st_addr  <= mem_addr;
                st_data  <= mem_wdata;
            end
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [3:0] fn,
                                          input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        enc_r = {op, fn, rd, rs1, 4'h0, rs2, 8'h00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [3:0] op, input logic [3:0] fn,
                                          input logic [3:0] rd, input logic [3:0] rs1, input logic [15:0] imm);
        enc_i = {op, fn, rd, rs1, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    // Hold reset for two cycles and release it on a falling edge; the caller is then in cycle 1.
    task automatic start();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Count cycles from the current one until retire, snapshot the port, then move to the next cycle.
    task automatic step_retire(output int n, output logic we_o, output logic [31:0] a_o, output logic [31:0] wd_o);
        n = 1;
        while (retire !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (retire !== 1'b1) n = 0;
        we_o = mem_we;
        a_o  = mem_addr;
        wd_o = mem_wdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n; logic w; logic [31:0] a, d;
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd1, 4'd0, 16'd5));
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL reset_pc got %h want 40", pc_out); end
        n_checks++; if (halted !== 1'b0 || retire !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_flags got h%b r%b w%b want 000", halted, retire, mem_we); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        start();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_fail++; $display("FAIL first_fetch got req%b addr %h we%b want 1 40 0", mem_req, mem_addr, mem_we); end
        step_retire(n, w, a, d);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL addi_latency got %0d want 4", n); end
        n_checks++; if (pc_out !== 32'h44) begin n_fail++; $display("FAIL addi_pc got %h want 44", pc_out); end
        n_checks++; if (dut.regs_q[1] !== 32'd5) begin n_fail++; $display("FAIL addi_r1 got %h want 5", dut.regs_q[1]); end
        n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL retire_pulse got %b want 0", retire); end
    endtask

    task automatic test_fetch_wait();
        int n; logic w; logic [31:0] a, d;
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd1, 4'd0, 16'd7));
        ack_delay = 3;
        start();
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL wait_stable c%0d got req%b addr %h want 1 40", c, mem_req, mem_addr); end
            if (c < 3) @(negedge clk);
        end
        step_retire(n, w, a, d);
        ack_delay = 0;
        n_checks++; if (n + 3 !== 7) begin n_fail++; $display("FAIL wait_latency got %0d want 7", n + 3); end
        n_checks++; if (dut.regs_q[1] !== 32'd7) begin n_fail++; $display("FAIL wait_r1 got %h want 7", dut.regs_q[1]); end
    endtask

    task automatic run_branch(input logic [3:0] fn, input logic [31:0] exp_pc);
        int n; logic w; logic [31:0] a, d;
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd2, 4'd0, 16'd3));
        put(32'h44, enc_i(ALUI, 4'h0, 4'd3, 4'd0, 16'd3));
        put(32'h50, enc_i(BCOND, fn, 4'd2, 4'd3, 16'hFFFE));
        start();
        for (int k = 0; k < 4; k++) step_retire(n, w, a, d);
        step_retire(n, w, a, d);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL br%h_latency got %0d want 3", fn, n); end
        n_checks++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL br%h_pc got %h want %h", fn, pc_out, exp_pc); end
    endtask

    task automatic test_branch();
        run_branch(4'h1, 32'h4C);
        run_branch(4'h9, 32'h54);
    endtask

    task automatic test_load_store();
        int n; logic w; logic [31:0] a, d;
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd4, 4'd0, 16'h7000));
        put(32'h44, enc_i(ALUI, 4'h0, 4'd4, 4'd4, 16'h6EAD));
        put(32'h48, enc_i(ALUI, 4'h0, 4'd5, 4'd0, 16'h0100));
        put(32'h4C, enc_i(SW, 4'h0, 4'd4, 4'd5, 16'd4));
        put(32'h50, enc_i(LW, 4'h0, 4'd8, 4'd5, 16'd4));
        start();
        for (int k = 0; k < 3; k++) step_retire(n, w, a, d);
        step_retire(n, w, a, d);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL sw_latency got %0d want 4", n); end
        n_checks++; if (w !== 1'b1 || a !== 32'h104 || d !== 32'hDEAD) begin n_fail++; $display("FAIL sw_bus got we%b %h %h want 1 104 dead", w, a, d); end
        n_checks++; if (st_addr !== 32'h104 || st_data !== 32'hDEAD) begin n_fail++; $display("FAIL sw_mem got %h %h want 104 dead", st_addr, st_data); end
        step_retire(n, w, a, d);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL lw_latency got %0d want 5", n); end
        n_checks++; if (dut.regs_q[8] !== 32'hDEAD) begin n_fail++; $display("FAIL lw_data got %h want dead", dut.regs_q[8]); end
        n_checks++; if (pc_out !== 32'h54) begin n_fail++; $display("FAIL lw_pc got %h want 54", pc_out); end
    endtask

    task automatic test_jal();
        int n; logic w; logic [31:0] a, d;
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd6, 4'd0, 16'h0200));
        put(32'h60, enc_i(JAL, 4'h0, 4'd15, 4'd6, 16'd2));
        start();
        for (int k = 0; k < 8; k++) step_retire(n, w, a, d);
        step_retire(n, w, a, d);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL jal_latency got %0d want 4", n); end
        n_checks++; if (dut.regs_q[15] !== 32'h64) begin n_fail++; $display("FAIL jal_link got %h want 64", dut.regs_q[15]); end
        n_checks++; if (pc_out !== 32'h208) begin n_fail++; $display("FAIL jal_pc got %h want 208", pc_out); end
    endtask

    task automatic test_alu();
        int n; logic w; logic [31:0] a, d;
        logic [31:0] expv [3:13];
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd1, 4'd0, 16'd12));
        put(32'h44, enc_i(ALUI, 4'h0, 4'd2, 4'd0, 16'd10));
        put(32'h48, enc_r(ALUR, 4'h1, 4'd3, 4'd1, 4'd2));
        put(32'h4C, enc_r(ALUR, 4'h4, 4'd4, 4'd1, 4'd2));
        put(32'h50, enc_r(ALUR, 4'h5, 4'd5, 4'd1, 4'd2));
        put(32'h54, enc_r(ALUR, 4'h6, 4'd6, 4'd1, 4'd2));
        put(32'h58, enc_r(ALUR, 4'hC, 4'd7, 4'd1, 4'd2));
        put(32'h5C, enc_r(ALUR, 4'hD, 4'd8, 4'd1, 4'd2));
        put(32'h60, enc_r(ALUR, 4'hE, 4'd9, 4'd1, 4'd2));
        put(32'h64, enc_r(CMPR, 4'h2, 4'd10, 4'd2, 4'd1));
        put(32'h68, enc_i(CMPI, 4'hB, 4'd11, 4'd1, 16'hFFFF));
        put(32'h6C, enc_i(CMPI, 4'h2, 4'd12, 4'd1, 16'hFFFF));
        put(32'h70, enc_r(ALUR, 4'h1, 4'd13, 4'd2, 4'd1));
        expv[3] = 32'h2;        expv[4] = 32'h8;        expv[5] = 32'hE;        expv[6] = 32'h6;
        expv[7] = 32'hFFFFFFF7; expv[8] = 32'hFFFFFFF1; expv[9] = 32'hFFFFFFF9;
        expv[10] = 32'h1;       expv[11] = 32'h1;       expv[12] = 32'h0;       expv[13] = 32'hFFFFFFFE;
        start();
        for (int k = 0; k < 13; k++) step_retire(n, w, a, d);
        for (int r = 3; r <= 13; r++) begin
            n_checks++; if (dut.regs_q[r] !== expv[r]) begin n_fail++; $display("FAIL alu_r%0d got %h want %h", r, dut.regs_q[r], expv[r]); end
        end
    endtask

    task automatic test_halt_reset();
        int n; logic w; logic [31:0] a, d;
        clear_mem();
        put(32'h40, enc_i(ALUI, 4'h0, 4'd1, 4'd0, 16'd1));
        put(32'h44, 32'hF000_0000);
        start();
        step_retire(n, w, a, d);
        ack_delay = 5;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL midfetch_req got req%b addr %h want 1 44", mem_req, mem_addr); end
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_drop_req got %b want 0", mem_req); end
        n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL reset_async_pc got %h want 40", pc_out); end
        ack_delay = 0;
        start();
        step_retire(n, w, a, d);
        for (int c = 0; c < 10 && halted !== 1'b1; c++) @(negedge clk);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b want 1", halted); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (mem_req !== 1'b0 || retire !== 1'b0 || pc_out !== 32'h44 || halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_frozen c%0d got req%b ret%b pc %h h%b want 0 0 44 1", c, mem_req, retire, pc_out, halted);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b want 0", halted); end
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_branch();
        test_load_store();
        test_jal();
        test_alu();
        test_halt_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
